// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Coin values, coin_out bit positions and dispenser FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  localparam int C_BIT_NICKEL  = 0;
  localparam int C_BIT_DIME    = 1;
  localparam int C_BIT_QUARTER = 2;

  localparam logic [7:0] C_VAL_NICKEL  = 8'd5;
  localparam logic [7:0] C_VAL_DIME    = 8'd10;
  localparam logic [7:0] C_VAL_QUARTER = 8'd25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Value in cents of a one-hot coin selection; zero when nothing is selected.
  function automatic logic [7:0] coin_value(input logic [2:0] pick);
    logic [7:0] v;
    v = 8'd0;
    if (pick[C_BIT_QUARTER])   v = C_VAL_QUARTER;
    else if (pick[C_BIT_DIME]) v = C_VAL_DIME;
    else if (pick[C_BIT_NICKEL]) v = C_VAL_NICKEL;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_select.sv
`default_nettype none
// ============================================================================
// Module      : coin_select
// Description : Greedy picker - largest coin that fits and whose tube is not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_select
  import vend_pkg::*;
(
  input  logic [7:0]  remaining,
  input  logic [11:0] tubes,
  output logic [2:0]  pick,
  output logic        valid
);

  logic w_q_ok;
  logic w_d_ok;
  logic w_n_ok;

  assign w_q_ok = (remaining >= C_VAL_QUARTER) && (tubes[4*C_BIT_QUARTER +: 4] != 4'd0);
  assign w_d_ok = (remaining >= C_VAL_DIME)    && (tubes[4*C_BIT_DIME    +: 4] != 4'd0);
  assign w_n_ok = (remaining >= C_VAL_NICKEL)  && (tubes[4*C_BIT_NICKEL  +: 4] != 4'd0);

  always_comb begin
    pick = 3'b000;
    if (w_q_ok)      pick[C_BIT_QUARTER] = 1'b1;
    else if (w_d_ok) pick[C_BIT_DIME]    = 1'b1;
    else if (w_n_ok) pick[C_BIT_NICKEL]  = 1'b1;
    valid = |pick;
  end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Returns change as timed coin pulses from three finite coin tubes.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_TICKS = 4,
  parameter int GAP_TICKS   = 4,
  parameter int TUBE_INIT   = 8,
  parameter int TUBE_MAX    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  amount,
  input  logic        refill,
  output logic        busy,
  output logic        change_returning,
  output logic [7:0]  change_due,
  output logic [2:0]  coin_out,
  output logic        done,
  output logic        short_change,
  output logic [11:0] tube_count
);

  localparam int MAX_TICKS = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_TICKS - 1);
  localparam logic [11:0]      C_TUBES_INIT = {3{4'(TUBE_INIT)}};
  localparam logic [11:0]      C_TUBES_MAX  = {3{4'(TUBE_MAX)}};

  state_t           r_state;
  logic [7:0]       r_due;
  logic [11:0]      r_tubes;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_coin;

  state_t           w_state_nxt;
  logic [7:0]       w_due_nxt;
  logic [11:0]      w_tubes_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_coin_nxt;
  logic [2:0]       w_pick;
  logic             w_valid;

  coin_select u_coin_select (
    .remaining (r_due),
    .tubes     (r_tubes),
    .pick      (w_pick),
    .valid     (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_due   <= 8'd0;
      r_tubes <= C_TUBES_INIT;
      r_cnt   <= '0;
      r_coin  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_due   <= w_due_nxt;
      r_tubes <= w_tubes_nxt;
      r_cnt   <= w_cnt_nxt;
      r_coin  <= w_coin_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_due_nxt   = r_due;
    w_tubes_nxt = r_tubes;
    w_cnt_nxt   = r_cnt;
    w_coin_nxt  = r_coin;
    case (r_state)
      ST_IDLE: begin
        if (refill) w_tubes_nxt = C_TUBES_MAX;
        if (start) begin
          w_state_nxt = ST_SELECT;
          w_due_nxt   = amount;
        end
      end
      ST_SELECT: begin
        if (r_due == 8'd0) begin
          w_state_nxt = ST_DONE;
        end else if (w_valid) begin
          w_state_nxt = ST_PULSE;
          w_due_nxt   = r_due - coin_value(w_pick);
          w_coin_nxt  = w_pick;
          w_cnt_nxt   = C_PULSE_LOAD;
          for (int i = 0; i < 3; i++) begin
            if (w_pick[i]) w_tubes_nxt[4*i +: 4] = r_tubes[4*i +: 4] - 4'd1;
          end
        end else begin
          // Remainder stays in change_due so DONE can flag short change.
          w_state_nxt = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = C_GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) w_state_nxt = ST_SELECT;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy             = (r_state != ST_IDLE);
  assign change_returning = (r_state == ST_SELECT) || (r_state == ST_PULSE) || (r_state == ST_GAP);
  assign done             = (r_state == ST_DONE);
  assign short_change     = (r_state == ST_DONE) && (r_due != 8'd0);
  assign coin_out         = (r_state == ST_PULSE) ? r_coin : 3'b000;
  assign change_due       = r_due;
  assign tube_count       = r_tubes;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Scoreboard bench for change_dispenser with directed requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam logic [2:0] C_N = 3'b001;
  localparam logic [2:0] C_D = 3'b010;
  localparam logic [2:0] C_Q = 3'b100;
  localparam int         C_PULSE = 4;

  typedef struct {
    int         lat;
    logic       sh;
    logic [7:0] due;
    logic [11:0] tubes;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  amount = 8'd0;
  logic        refill = 1'b0;
  logic        busy;
  logic        change_returning;
  logic [7:0]  change_due;
  logic [2:0]  coin_out;
  logic        done;
  logic        short_change;
  logic [11:0] tube_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_edge = 0;

  logic [2:0] exp_coin[$];
  done_t      exp_done[$];

  change_dispenser dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .amount           (amount),
    .refill           (refill),
    .busy             (busy),
    .change_returning (change_returning),
    .change_due       (change_due),
    .coin_out         (coin_out),
    .done             (done),
    .short_change     (short_change),
    .tube_count       (tube_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input int lat, input logic sh, input logic [7:0] due, input logic [11:0] tubes);
    done_t d;
    d.lat = lat; d.sh = sh; d.due = due; d.tubes = tubes;
    exp_done.push_back(d);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the SELECT cycle.
  task automatic issue(input logic [7:0] amt, input logic do_refill);
    @(negedge clk);
    start = 1'b1; amount = amt; refill = do_refill; start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0; refill = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("returning_in_select", 32'(change_returning), 32'd1);
    chk("due_loaded", 32'(change_due), 32'(amt));
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", 32'(seen), 32'd1);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: coin identity and pulse width, completion record and latency.
  initial begin
    int pulse_len;
    done_t d;
    pulse_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulse_len = 0;
      end else begin
        if (coin_out != 3'b000) begin
          if (pulse_len == 0) begin
            chk("coin_expected", 32'(exp_coin.size() != 0), 32'd1);
            if (exp_coin.size() != 0) chk("coin_value", 32'(coin_out), 32'(exp_coin.pop_front()));
          end
          pulse_len++;
        end else if (pulse_len != 0) begin
          chk("pulse_width", 32'(pulse_len), 32'(C_PULSE));
          pulse_len = 0;
        end
        if (short_change) chk("short_with_done", 32'(done), 32'd1);
        if (done) begin
          chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
          if (exp_done.size() != 0) begin
            d = exp_done.pop_front();
            chk("done_latency", 32'(cyc - start_edge), 32'(d.lat));
            chk("short_change", 32'(short_change), 32'(d.sh));
            chk("change_due", 32'(change_due), 32'(d.due));
            chk("tube_count", 32'(tube_count), 32'(d.tubes));
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_returning", 32'(change_returning), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_short", 32'(short_change), 32'd0);
    chk("rst_coin", 32'(coin_out), 32'd0);
    chk("rst_due", 32'(change_due), 32'd0);
    chk("rst_tubes", 32'(tube_count), 32'h888);

    // 40c: quarter, dime, nickel; done 28 edges after the sampling edge
    exp_coin.push_back(C_Q); exp_coin.push_back(C_D); exp_coin.push_back(C_N);
    expect_done(28, 1'b0, 8'd0, 12'h777);
    issue(8'd40, 1'b0);
    wait_done(200);

    // Zero amount: SELECT then DONE
    expect_done(1, 1'b0, 8'd0, 12'h777);
    issue(8'd0, 1'b0);
    wait_done(50);

    // Empty the quarter tube, then 50c must come as five dimes
    do_reset();
    repeat (8) exp_coin.push_back(C_Q);
    expect_done(73, 1'b0, 8'd0, 12'h088);
    issue(8'd200, 1'b0);
    wait_done(300);
    repeat (5) exp_coin.push_back(C_D);
    expect_done(46, 1'b0, 8'd0, 12'h038);
    issue(8'd50, 1'b0);
    wait_done(300);

    // 7c: one nickel then short change with 2c remaining
    exp_coin.push_back(C_N);
    expect_done(10, 1'b1, 8'd2, 12'h037);
    issue(8'd7, 1'b0);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("due_held_idle", 32'(change_due), 32'd2);

    // Refill alone in IDLE
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    chk("refill_tubes", 32'(tube_count), 32'hFFF);
    chk("refill_not_busy", 32'(busy), 32'd0);

    // 35c with a stray start during PULSE and a refill while busy
    exp_coin.push_back(C_Q); exp_coin.push_back(C_D);
    expect_done(19, 1'b0, 8'd0, 12'hEEF);
    issue(8'd35, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; amount = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    wait_done(200);

    // Reset mid-PULSE of 25c: request abandoned, no done
    do_reset();
    exp_coin.push_back(C_Q);
    issue(8'd25, 1'b0);
    repeat (2) @(negedge clk);
    chk("pulse_active", 32'(coin_out), 32'(C_Q));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_coin", 32'(coin_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_due", 32'(change_due), 32'd0);
    chk("midrst_tubes", 32'(tube_count), 32'h888);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Drain every tube, then refill and start together
    repeat (8) exp_coin.push_back(C_Q);
    expect_done(73, 1'b0, 8'd0, 12'h088);
    issue(8'd200, 1'b0);
    wait_done(300);
    repeat (8) exp_coin.push_back(C_D);
    expect_done(73, 1'b0, 8'd0, 12'h008);
    issue(8'd80, 1'b0);
    wait_done(300);
    repeat (8) exp_coin.push_back(C_N);
    expect_done(73, 1'b0, 8'd0, 12'h000);
    issue(8'd40, 1'b0);
    wait_done(300);
    exp_coin.push_back(C_D); exp_coin.push_back(C_N);
    expect_done(19, 1'b0, 8'd0, 12'hFEE);
    issue(8'd15, 1'b1);
    wait_done(200);

    repeat (3) @(negedge clk);
    chk("coins_outstanding", 32'(exp_coin.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_done.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
